// File: rtl/irq_pkg.sv
// ---------------------------------------------------------------------------
// irq_pkg
// Shared constants for the interrupt controller and the execute stage:
//   - execute-stage state encodings (ST_IDLE .. ST_VAZIO_0 = 0 .. 6)
//   - opcode constants shared with the execute stage
//   - NUM_IRQ / MAX_NEST sizing constants
//   - prio_onehot(): lowest set bit as one-hot (bit0 = highest priority)
//   - popcount():    number of set bits in a request/service bitmap
// ---------------------------------------------------------------------------
package irq_pkg;

  localparam int NUM_IRQ  = 4;
  // Bounded by the execute stage PC stack depth (5).
  localparam int MAX_NEST = 4;
  localparam logic [2:0] MAX_NEST_W = 3'(MAX_NEST);

  // Execute-stage states
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_DECODE  = 3'd2;
  localparam logic [2:0] ST_EXEC    = 3'd3;
  localparam logic [2:0] ST_SEND    = 3'd4;
  localparam logic [2:0] ST_BRANCH  = 3'd5;
  localparam logic [2:0] ST_VAZIO_0 = 3'd6;

  // Opcodes shared with the execute stage
  localparam logic [4:0] OPC_NOP = 5'b00000;
  localparam logic [4:0] OPC_JR  = 5'b01100;
  localparam logic [4:0] OPC_RET = 5'b01110;

  // Isolate the lowest set bit: v & (two's complement of v). Zero in, zero out.
  function automatic logic [NUM_IRQ-1:0] prio_onehot(input logic [NUM_IRQ-1:0] v);
    return v & (~v + 4'd1);
  endfunction

  function automatic logic [2:0] popcount(input logic [NUM_IRQ-1:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// ---------------------------------------------------------------------------
// irq_controller_if
// Bundles the execute-stage / peripheral side signals of the interrupt
// controller. Directions are named from the controller's viewpoint.
//   i_irq_req[3:0]   peripheral request lines (bit0 highest priority)
//   i_mask_we        mask register write enable
//   i_mask_in[3:0]   mask value, 1 = line enabled
//   i_estado[2:0]    execute-stage FSM state
//   i_opcd_in[4:0]   opcode held by the execute stage
//   o_interrupt[3:0] one-hot request to the execute stage
//   o_irq_ack[3:0]   one-cycle acknowledge to the peripheral
//   o_in_service[3:0] in-service bitmap
//   o_pending[3:0]   pending bitmap (before masking)
//   o_err_ret        sticky RET-underflow flag
// Modports: master = controller, slave = execute stage / peripherals.
// ---------------------------------------------------------------------------
interface irq_controller_if;
  logic [3:0] i_irq_req;
  logic       i_mask_we;
  logic [3:0] i_mask_in;
  logic [2:0] i_estado;
  logic [4:0] i_opcd_in;
  logic [3:0] o_interrupt;
  logic [3:0] o_irq_ack;
  logic [3:0] o_in_service;
  logic [3:0] o_pending;
  logic       o_err_ret;

  modport master (
    input  i_irq_req, i_mask_we, i_mask_in, i_estado, i_opcd_in,
    output o_interrupt, o_irq_ack, o_in_service, o_pending, o_err_ret
  );

  modport slave (
    output i_irq_req, i_mask_we, i_mask_in, i_estado, i_opcd_in,
    input  o_interrupt, o_irq_ack, o_in_service, o_pending, o_err_ret
  );
endinterface

// File: rtl/irq_edge_capture.sv
// ---------------------------------------------------------------------------
// irq_edge_capture
// Rising-edge request latch. Keeps the previous-cycle value of each request
// line; a 0->1 transition sets the pending bit, an issue clears it. When both
// happen on the same edge the set wins, so a fresh request is never lost.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_req[3:0]       raw request lines
//   i_clr[3:0]       one-hot clear from the issue logic
//   o_pending[3:0]   latched pending bitmap
// ---------------------------------------------------------------------------
module irq_edge_capture
  import irq_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_IRQ-1:0] i_req,
  input  logic [NUM_IRQ-1:0] i_clr,
  output logic [NUM_IRQ-1:0] o_pending
);

  logic [NUM_IRQ-1:0] r_prev;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] w_rise;

  assign w_rise = i_req & ~r_prev;

  // Previous-value register and pending set/clear (set has priority).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev    <= 4'd0;
      r_pending <= 4'd0;
    end else begin
      r_prev    <= i_req;
      r_pending <= (r_pending & ~i_clr) | w_rise;
    end
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/irq_controller.sv
// ---------------------------------------------------------------------------
// irq_controller
// Initiator side of the execute-stage interrupt interface. Latches peripheral
// requests, applies the mask and fixed priority (bit0 highest), and issues a
// one-cycle one-hot INTERRUPT that lines up with the execute stage's
// ST_BRANCH cycle. Tracks nested in-service levels and retires the highest
// priority one when the execute stage runs RET in ST_BRANCH.
// Ports:
//   i_clk     clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   bus       irq_controller_if.master (requests, mask, ESTADO, OPCD in;
//             INTERRUPT, IRQ_ACK, IN_SERVICE, PENDING, ERR_RET out)
// Configuration macro: IRQ_LEVEL_TRIG_EN
//   defined   -> level-sensitive requests, PENDING = IRQ_REQ & ~IN_SERVICE
//   undefined -> rising-edge latched requests (irq_edge_capture)
// ---------------------------------------------------------------------------
module irq_controller
  import irq_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  irq_controller_if.master bus
);

  logic [NUM_IRQ-1:0] r_mask;
  logic [NUM_IRQ-1:0] r_in_service;
  logic [NUM_IRQ-1:0] r_interrupt;
  logic               r_err_ret;

  logic [NUM_IRQ-1:0] w_pending;
  logic [NUM_IRQ-1:0] w_eligible;
  logic [NUM_IRQ-1:0] w_cand;
  logic [NUM_IRQ-1:0] w_cand_le;
  logic               w_issue;
  logic               w_retire;
  logic [NUM_IRQ-1:0] w_mask_nxt;
  logic [NUM_IRQ-1:0] w_in_service_nxt;
  logic [NUM_IRQ-1:0] w_interrupt_nxt;
  logic               w_err_nxt;

`ifdef IRQ_LEVEL_TRIG_EN
  // No latch: a line that drops before ST_SEND simply is not issued.
  assign w_pending = bus.i_irq_req & ~r_in_service;
`else
  logic [NUM_IRQ-1:0] w_clr;

  assign w_clr = w_issue ? w_cand : 4'd0;

  irq_edge_capture u_edge_capture (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_req     (bus.i_irq_req),
    .i_clr     (w_clr),
    .o_pending (w_pending)
  );
`endif

  // Candidate selection and issue/retire qualification.
  always_comb begin
    w_eligible = w_pending & r_mask;
    w_cand     = prio_onehot(w_eligible);
    // All positions at or below the candidate; any in-service bit there blocks it.
    w_cand_le  = w_cand | (w_cand - 4'd1);
    w_issue    = 1'b0;
    w_retire   = 1'b0;
    if ((bus.i_estado == ST_SEND) && (w_cand != 4'd0) &&
        ((r_in_service & w_cand_le) == 4'd0) &&
        (popcount(r_in_service) < MAX_NEST_W)) begin
      w_issue = 1'b1;
    end else begin
      w_issue = 1'b0;
    end
    // A RET in the same branch window as a fresh INTERRUPT belongs to the
    // interrupted code path, not to a service routine, so it is ignored.
    if ((bus.i_estado == ST_BRANCH) && (bus.i_opcd_in == OPC_RET) &&
        (r_interrupt == 4'd0)) begin
      w_retire = 1'b1;
    end else begin
      w_retire = 1'b0;
    end
  end

  // Next-state values for the mask, in-service bitmap, output and error flag.
  always_comb begin
    w_in_service_nxt = r_in_service;
    w_interrupt_nxt  = 4'd0;
    w_err_nxt        = r_err_ret;
    if (w_issue) begin
      w_in_service_nxt = r_in_service | w_cand;
      w_interrupt_nxt  = w_cand;
    end else if (w_retire) begin
      if (r_in_service == 4'd0) begin
        w_err_nxt = 1'b1;
      end else begin
        w_in_service_nxt = r_in_service & ~prio_onehot(r_in_service);
      end
    end else begin
      w_in_service_nxt = r_in_service;
    end
    // The mask write takes effect after this edge; this cycle's decision used r_mask.
    if (bus.i_mask_we) begin
      w_mask_nxt = bus.i_mask_in;
    end else begin
      w_mask_nxt = r_mask;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mask       <= 4'b1111;
      r_in_service <= 4'd0;
      r_interrupt  <= 4'd0;
      r_err_ret    <= 1'b0;
    end else begin
      r_mask       <= w_mask_nxt;
      r_in_service <= w_in_service_nxt;
      r_interrupt  <= w_interrupt_nxt;
      r_err_ret    <= w_err_nxt;
    end
  end

  assign bus.o_interrupt  = r_interrupt;
  assign bus.o_irq_ack    = r_interrupt;
  assign bus.o_in_service = r_in_service;
  assign bus.o_pending    = w_pending;
  assign bus.o_err_ret    = r_err_ret;

endmodule

// File: tb/tb_irq_controller.sv
// ---------------------------------------------------------------------------
// tb_irq_controller
// Scoreboard bench: the driver applies one cycle of stimulus, steps a
// behavioural model of the controller rules, and queues the expected outputs
// after the following clock edge; a monitor pops and compares at each falling
// edge. Directed scenarios come first, then randomized traffic.
// ---------------------------------------------------------------------------
module tb_irq_controller;
  import irq_pkg::*;

  typedef struct packed {
    logic [3:0] intr;
    logic [3:0] ack;
    logic [3:0] svc;
    logic [3:0] pend;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  irq_controller_if bus_if ();

  irq_controller dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_if.master)
  );

  int n_chk  = 0;
  int n_pass = 0;

  exp_t exp_q[$];
  exp_t exp_hold;
  bit   have_exp = 1'b0;

  // Behavioural model state
  bit m_pend[NUM_IRQ];
  bit m_svc[NUM_IRQ];
  bit m_prev[NUM_IRQ];
  bit m_mask[NUM_IRQ];
  bit m_err;
  int m_int;   // line currently presented on INTERRUPT, -1 when none

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_IRQ; i++) begin
      m_pend[i] = 1'b0;
      m_svc[i]  = 1'b0;
      m_prev[i] = 1'b0;
      m_mask[i] = 1'b1;
    end
    m_err = 1'b0;
    m_int = -1;
  endtask

  // One clock edge worth of controller behaviour, from the rules.
  task automatic model_step(input logic [3:0] irq, input logic mwe, input logic [3:0] mval,
                            input logic [2:0] st, input logic [4:0] op, output exp_t e);
    bit pend_eff[NUM_IRQ];
    int cand = -1;
    int depth = 0;
    int top_svc = NUM_IRQ;
    bit issue;
    bit ret;
    int new_int = -1;
    for (int i = 0; i < NUM_IRQ; i++) begin
`ifdef IRQ_LEVEL_TRIG_EN
      pend_eff[i] = irq[i] && !m_svc[i];
`else
      pend_eff[i] = m_pend[i];
`endif
      if (m_svc[i]) begin
        depth++;
        if (i < top_svc) top_svc = i;
      end
    end
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend_eff[i] && m_mask[i]) cand = i;
    end
    issue = (st == ST_SEND) && (cand >= 0) && (cand < top_svc) && (depth < MAX_NEST);
    ret   = (st == ST_BRANCH) && (op == OPC_RET) && (m_int < 0);
    if (issue) begin
      m_svc[cand]  = 1'b1;
      m_pend[cand] = 1'b0;
      new_int      = cand;
    end else if (ret) begin
      if (depth == 0) m_err = 1'b1;
      else            m_svc[top_svc] = 1'b0;
    end
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (irq[i] && !m_prev[i]) m_pend[i] = 1'b1;
      m_prev[i] = irq[i];
      if (mwe) m_mask[i] = mval[i];
    end
    m_int = new_int;
    e.intr = (m_int >= 0) ? (4'd1 << m_int) : 4'd0;
    e.ack  = e.intr;
    e.err  = m_err;
    for (int i = 0; i < NUM_IRQ; i++) begin
      e.svc[i] = m_svc[i];
`ifdef IRQ_LEVEL_TRIG_EN
      e.pend[i] = irq[i] && !m_svc[i];
`else
      e.pend[i] = m_pend[i];
`endif
    end
  endtask

  // Drive one cycle; the expectation for the previous cycle's edge is now due.
  task automatic apply(input logic [3:0] irq, input logic mwe, input logic [3:0] mval,
                       input logic [2:0] st, input logic [4:0] op);
    exp_t e;
    @(posedge clk);
    #1;
    if (have_exp) exp_q.push_back(exp_hold);
    bus_if.i_irq_req = irq;
    bus_if.i_mask_we = mwe;
    bus_if.i_mask_in = mval;
    bus_if.i_estado  = st;
    bus_if.i_opcd_in = op;
    model_step(irq, mwe, mval, st, op, e);
    exp_hold = e;
    have_exp = 1'b1;
  endtask

  // One execute-stage loop: irq_early in IDLE/FETCH, irq_late from DECODE on,
  // op in the branch cycle, optional mask write in the ST_SEND cycle.
  task automatic frame(input logic [3:0] irq_early, input logic [3:0] irq_late,
                       input logic [4:0] op, input logic mwe, input logic [3:0] mval);
    for (int s = 0; s < 7; s++) begin
      apply((s < 2) ? irq_early : irq_late,
            (s == 4) ? mwe : 1'b0, mval, 3'(s),
            (s == 5) ? op : OPC_NOP);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("interrupt",  bus_if.o_interrupt,  e.intr);
        chk("irq_ack",    bus_if.o_irq_ack,    e.ack);
        chk("in_service", bus_if.o_in_service, e.svc);
        chk("pending",    bus_if.o_pending,    e.pend);
        chk("err_ret",    {3'd0, bus_if.o_err_ret}, {3'd0, e.err});
      end
    end
  end

  initial begin
    logic [3:0] irq_r;
    logic [4:0] op_r;
    bus_if.i_irq_req = 4'd0;
    bus_if.i_mask_we = 1'b0;
    bus_if.i_mask_in = 4'd0;
    bus_if.i_estado  = ST_IDLE;
    bus_if.i_opcd_in = OPC_NOP;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_interrupt",  bus_if.o_interrupt,  4'd0);
    chk("rst_in_service", bus_if.o_in_service, 4'd0);
    chk("rst_pending",    bus_if.o_pending,    4'd0);
    chk("rst_err_ret",    {3'd0, bus_if.o_err_ret}, 4'd0);
    rst_n = 1'b1;

    // Single request on line 2, then RET
    frame(4'b0000, 4'b0100, OPC_NOP, 1'b0, 4'd0);
    frame(4'b0100, 4'b0000, OPC_NOP, 1'b0, 4'd0);
    frame(4'b0000, 4'b0000, OPC_RET, 1'b0, 4'd0);
    // Priority: lines 3 and 1 together
    frame(4'b0000, 4'b1010, OPC_NOP, 1'b0, 4'd0);
    frame(4'b1010, 4'b0000, OPC_RET, 1'b0, 4'd0);
    frame(4'b0000, 4'b0000, OPC_NOP, 1'b0, 4'd0);
    frame(4'b0000, 4'b0000, OPC_RET, 1'b0, 4'd0);
    // Preemption and nesting
    frame(4'b0000, 4'b0100, OPC_NOP, 1'b0, 4'd0);
    frame(4'b0100, 4'b0101, OPC_NOP, 1'b0, 4'd0);
    frame(4'b0101, 4'b1101, OPC_NOP, 1'b0, 4'd0);
    frame(4'b1101, 4'b0000, OPC_RET, 1'b0, 4'd0);
    frame(4'b0000, 4'b0000, OPC_RET, 1'b0, 4'd0);
    frame(4'b0000, 4'b0000, OPC_NOP, 1'b0, 4'd0);
    frame(4'b0000, 4'b0000, OPC_RET, 1'b0, 4'd0);
    // Mask hold and release
    frame(4'b0000, 4'b0000, OPC_NOP, 1'b1, 4'b1110);
    frame(4'b0000, 4'b0001, OPC_NOP, 1'b0, 4'd0);
    frame(4'b0001, 4'b0001, OPC_NOP, 1'b1, 4'b1111);
    frame(4'b0001, 4'b0000, OPC_NOP, 1'b0, 4'd0);
    frame(4'b0000, 4'b0000, OPC_RET, 1'b0, 4'd0);
    // RET underflow
    frame(4'b0000, 4'b0000, OPC_RET, 1'b0, 4'd0);
    frame(4'b0000, 4'b0000, OPC_NOP, 1'b0, 4'd0);

    // Reset asserted during the branch window
    for (int s = 0; s < 5; s++) apply((s < 2) ? 4'b0000 : 4'b0010, 1'b0, 4'd0, 3'(s), OPC_NOP);
    apply(4'b0010, 1'b0, 4'd0, ST_BRANCH, OPC_NOP);
    @(negedge clk);
    #1;
    chk("pre_rst_interrupt", bus_if.o_interrupt, 4'b0010);
    rst_n = 1'b0;
    #1;
    chk("async_rst_interrupt", bus_if.o_interrupt,  4'd0);
    chk("async_rst_irq_ack",   bus_if.o_irq_ack,    4'd0);
    chk("async_rst_in_service", bus_if.o_in_service, 4'd0);
    have_exp = 1'b0;
    bus_if.i_irq_req = 4'd0;
    bus_if.i_estado  = ST_IDLE;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_service", bus_if.o_in_service, 4'd0);
    chk("post_rst_pending",    bus_if.o_pending,    4'd0);

    // Randomized traffic through the steady-state execute loop
    irq_r = 4'd0;
    for (int c = 0; c < 2100; c++) begin
      logic [2:0] st;
      st = 3'(c % 7);
      if ($urandom_range(0, 3) == 0) irq_r = 4'($urandom_range(0, 15));
      if (st == ST_BRANCH) op_r = ($urandom_range(0, 1) == 0) ? OPC_RET : 5'($urandom_range(0, 31));
      else                 op_r = ($urandom_range(0, 3) == 0) ? OPC_RET : OPC_JR;
      apply(irq_r, ($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)), st, op_r);
    end

    // Flush the last expectation and confirm the scoreboard drained
    apply(4'd0, 1'b0, 4'd0, ST_IDLE, OPC_NOP);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 4'(exp_q.size()), 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
